// File: rtl/ctrlunit_mc_if.sv
// ctrlunit_mc_if -- bundle of signals between the multi-cycle control unit
// and its environment (instruction register, memory port, datapath).
//
// Signals:
//   opcode     : instruction opcode, sampled by the unit in DECODE
//   mem_ready  : memory completes the current read/write this cycle
//   aluOp      : ALU opcode
//   regDst     : register destination select (00/01 = Rd, 10 = link)
//   memToReg   : write-back source (00 = ALU, 01 = memory, 10 = link PC)
//   aluSrcA    : ALU A select (00 = Rs, 01 = PC, 10 = Rs[HI], 11 = 0)
//   aluSrcB    : ALU B select (00 = Rt, 01 = imm, 10 = Rt[LO], 11 = 0)
//   iord       : memory address select (0 = PC, 1 = ALU result)
//   irWrite, pcWrite, jump, branch, memRead, memWrite, regWrite : strobes
//   instr_done : pulse on the last cycle of each instruction
//   fault      : 00 none, 01 illegal opcode, 10 memory timeout (sticky)
//   state      : current sequencer state, for debug
//
// Modports: slave = the control unit, master = the environment driving it.
interface ctrlunit_mc_if #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic [ALUOP_W-1:0]  aluOp;
  logic [1:0]          regDst;
  logic [1:0]          memToReg;
  logic [1:0]          aluSrcA;
  logic [1:0]          aluSrcB;
  logic                iord;
  logic                irWrite;
  logic                pcWrite;
  logic                jump;
  logic                branch;
  logic                memRead;
  logic                memWrite;
  logic                regWrite;
  logic                instr_done;
  logic [1:0]          fault;
  logic [2:0]          state;

  modport slave (
    input  opcode, mem_ready,
    output aluOp, regDst, memToReg, aluSrcA, aluSrcB, iord, irWrite, pcWrite,
           jump, branch, memRead, memWrite, regWrite, instr_done, fault, state
  );

  modport master (
    output opcode, mem_ready,
    input  aluOp, regDst, memToReg, aluSrcA, aluSrcB, iord, irWrite, pcWrite,
           jump, branch, memRead, memWrite, regWrite, instr_done, fault, state
  );
endinterface

// File: rtl/ctrlunit_mc.sv
// ctrlunit_mc -- multi-cycle control unit. Steps every instruction through
// FETCH/DECODE/EXEC/MEM/WB, waits on a variable-latency memory via mem_ready,
// and traps (sticky fault) on illegal opcodes or memory timeouts.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset; all outputs are 0 while low
//   bus : ctrlunit_mc_if.slave -- opcode/mem_ready in, datapath controls out
//
// Opcode map (low 4 bits): 0000-0111 ALU op (aluOp = opcode[2:0]),
// 1000 ADI, 1001 SWP, 1010 LDW, 1011 STW, 1100 BRZ, 1101 JAL,
// 1110/1111 illegal.
module ctrlunit_mc #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3,
  parameter int TIMEOUT  = 15
) (
  input logic          clk,
  input logic          rst,
  ctrlunit_mc_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [3:0] OP_ADI = 4'b1000;
  localparam logic [3:0] OP_SWP = 4'b1001;
  localparam logic [3:0] OP_LDW = 4'b1010;
  localparam logic [3:0] OP_STW = 4'b1011;
  localparam logic [3:0] OP_BRZ = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1101;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;

  localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TIMEOUT_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_e           state_q;
  logic [3:0]       opc_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [1:0]       fault_q;

  logic illegal_op;
  logic timeout_hit;

  assign illegal_op = (bus.opcode[3:0] == 4'b1110) || (bus.opcode[3:0] == 4'b1111) ||
                      ((bus.opcode >> 4) != '0);

  // The wait cycle that would bring the counter to TIMEOUT is the last one
  // allowed; mem_ready in that same cycle still completes normally.
  assign timeout_hit = (TIMEOUT != 0) && !bus.mem_ready &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_M1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; a blocking '=' here would create order-
  // dependent simulation that no longer matches the synthesized flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      opc_q      <= '0;
      wait_cnt_q <= '0;
      fault_q    <= F_NONE;
    end else begin
      // Cleared on every cycle that is not a continued memory wait.
      wait_cnt_q <= '0;
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready) begin
            state_q <= S_DECODE;
          end else if (timeout_hit) begin
            state_q <= S_TRAP;
            fault_q <= F_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_DECODE: begin
          opc_q <= bus.opcode[3:0];
          if (illegal_op) begin
            state_q <= S_TRAP;
            fault_q <= F_ILLEGAL;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (opc_q)
            OP_LDW, OP_STW: state_q <= S_MEM;
            OP_BRZ, OP_JAL: state_q <= S_FETCH;
            default:        state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (opc_q == OP_LDW) state_q <= S_WB;
            else                 state_q <= S_FETCH;
          end else if (timeout_hit) begin
            state_q <= S_TRAP;
            fault_q <= F_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // EXEC-phase ALU selects, also held through WB for non-load instructions.
  logic [2:0] sel_alu;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sel_alu = 3'b000;
    sel_a   = 2'b00;
    sel_b   = 2'b00;
    if (!opc_q[3]) begin
      sel_alu = opc_q[2:0];
    end else begin
      case (opc_q)
        OP_ADI:                 sel_b = 2'b01;
        OP_SWP: begin
          sel_a = 2'b10;
          sel_b = 2'b10;
        end
        OP_LDW, OP_STW, OP_BRZ: sel_b = 2'b11;
        default: ;
      endcase
    end
  end

  logic [2:0] alu_op;
  logic [1:0] reg_dst, mem_to_reg, src_a, src_b, fault_o;
  logic       iord, ir_write, pc_write, jump, branch;
  logic       mem_read, mem_write, reg_write, done;
  logic [2:0] state_o;

  // Outputs decode from state/opc_q only (plus mem_ready for the completion
  // strobes) and are forced low while rst is asserted.
  always_comb begin
    alu_op     = 3'b000;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    fault_o    = 2'b00;
    state_o    = 3'd0;
    if (rst) begin
      fault_o = fault_q;
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = bus.mem_ready;
          pc_write = bus.mem_ready;
        end
        S_EXEC: begin
          alu_op = sel_alu;
          src_a  = sel_a;
          src_b  = sel_b;
          if (opc_q == OP_BRZ) begin
            branch = 1'b1;
            done   = 1'b1;
          end
          if (opc_q == OP_JAL) begin
            jump       = 1'b1;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            done       = 1'b1;
          end
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_read  = (opc_q == OP_LDW);
          mem_write = (opc_q == OP_STW);
          done      = (opc_q == OP_STW) && bus.mem_ready;
        end
        S_WB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          done      = 1'b1;
          if (opc_q == OP_LDW) begin
            mem_to_reg = 2'b01;
          end else begin
            alu_op = sel_alu;
            src_a  = sel_a;
            src_b  = sel_b;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.aluOp      = ALUOP_W'(alu_op);
  assign bus.regDst     = reg_dst;
  assign bus.memToReg   = mem_to_reg;
  assign bus.aluSrcA    = src_a;
  assign bus.aluSrcB    = src_b;
  assign bus.iord       = iord;
  assign bus.irWrite    = ir_write;
  assign bus.pcWrite    = pc_write;
  assign bus.jump       = jump;
  assign bus.branch     = branch;
  assign bus.memRead    = mem_read;
  assign bus.memWrite   = mem_write;
  assign bus.regWrite   = reg_write;
  assign bus.instr_done = done;
  assign bus.fault      = fault_o;
  assign bus.state      = state_o;

endmodule

// File: tb/tb_ctrlunit_mc.sv
// tb_ctrlunit_mc -- directed bench for ctrlunit_mc. Each cycle the expected
// control vector is pushed to a scoreboard as the inputs are driven, then
// popped and compared against the DUT on the falling edge.
`timescale 1ns/1ps
module tb_ctrlunit_mc;

  localparam int OPCODE_W = 4;
  localparam int ALUOP_W  = 3;
  localparam int TIMEOUT  = 15;

  localparam logic [3:0] OP_ADI = 4'b1000;
  localparam logic [3:0] OP_SWP = 4'b1001;
  localparam logic [3:0] OP_LDW = 4'b1010;
  localparam logic [3:0] OP_STW = 4'b1011;
  localparam logic [3:0] OP_BRZ = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1101;
  // Driven outside DECODE so a wrongly timed opcode capture shows up as a trap.
  localparam logic [3:0] JUNK   = 4'b1111;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] fault;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       done;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [1:0] fault_exp = 2'b00;
  ctl_t exp_q[$];

  ctrlunit_mc_if #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) bus ();

  ctrlunit_mc #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic ctl_t sample();
    ctl_t s;
    s.state      = bus.state;
    s.fault      = bus.fault;
    s.alu_op     = bus.aluOp;
    s.reg_dst    = bus.regDst;
    s.mem_to_reg = bus.memToReg;
    s.src_a      = bus.aluSrcA;
    s.src_b      = bus.aluSrcB;
    s.iord       = bus.iord;
    s.ir_write   = bus.irWrite;
    s.pc_write   = bus.pcWrite;
    s.jump       = bus.jump;
    s.branch     = bus.branch;
    s.mem_read   = bus.memRead;
    s.mem_write  = bus.memWrite;
    s.reg_write  = bus.regWrite;
    s.done       = bus.instr_done;
    return s;
  endfunction

  // ---------------- expected vectors, written from the state tables --------
  function automatic ctl_t zero_ctl();
    ctl_t e = '0;
    return e;
  endfunction

  function automatic ctl_t base(input logic [2:0] st);
    ctl_t e = '0;
    e.state = st;
    e.fault = fault_exp;
    return e;
  endfunction

  function automatic ctl_t exp_fetch(input logic rdy);
    ctl_t e = base(3'd0);
    e.mem_read = 1'b1;
    e.ir_write = rdy;
    e.pc_write = rdy;
    return e;
  endfunction

  function automatic ctl_t with_sel(input ctl_t e_in, input logic [3:0] op);
    ctl_t e = e_in;
    if (op < 4'd8) e.alu_op = op[2:0];
    else if (op == OP_ADI) e.src_b = 2'b01;
    else if (op == OP_SWP) begin
      e.src_a = 2'b10;
      e.src_b = 2'b10;
    end else if (op == OP_LDW || op == OP_STW || op == OP_BRZ) e.src_b = 2'b11;
    return e;
  endfunction

  function automatic ctl_t exp_exec(input logic [3:0] op);
    ctl_t e = with_sel(base(3'd2), op);
    if (op == OP_BRZ) begin
      e.branch = 1'b1;
      e.done   = 1'b1;
    end
    if (op == OP_JAL) begin
      e.jump       = 1'b1;
      e.reg_write  = 1'b1;
      e.reg_dst    = 2'b10;
      e.mem_to_reg = 2'b10;
      e.done       = 1'b1;
    end
    return e;
  endfunction

  function automatic ctl_t exp_mem(input logic [3:0] op, input logic rdy);
    ctl_t e = base(3'd3);
    e.iord      = 1'b1;
    e.mem_read  = (op == OP_LDW);
    e.mem_write = (op == OP_STW);
    e.done      = (op == OP_STW) && rdy;
    return e;
  endfunction

  function automatic ctl_t exp_wb(input logic [3:0] op);
    ctl_t e = base(3'd4);
    e.reg_write = 1'b1;
    e.reg_dst   = 2'b01;
    e.done      = 1'b1;
    if (op == OP_LDW) e.mem_to_reg = 2'b01;
    else              e = with_sel(e, op);
    return e;
  endfunction

  // ---------------- scoreboard check and per-cycle step --------------------
  task automatic check(input string tag, input ctl_t obs);
    ctl_t exp;
    exp = exp_q.pop_front();
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive inputs, compare on the falling
  // edge, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [3:0] op, input logic rdy, input ctl_t e);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    check(tag, sample());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    fault_exp = 2'b00;
    exp_q.push_back(zero_ctl());
    check({tag, "/async"}, sample());
    @(negedge clk);
    exp_q.push_back(zero_ctl());
    check({tag, "/held"}, sample());
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op, input int fwait, input int mwait);
    for (int i = 0; i < fwait; i++) step({tag, "/fetch_wait"}, JUNK, 1'b0, exp_fetch(1'b0));
    step({tag, "/fetch"}, JUNK, 1'b1, exp_fetch(1'b1));
    step({tag, "/decode"}, op, 1'b1, base(3'd1));
    step({tag, "/exec"}, JUNK, 1'b1, exp_exec(op));
    if (op == OP_LDW || op == OP_STW) begin
      for (int i = 0; i < mwait; i++) step({tag, "/mem_wait"}, JUNK, 1'b0, exp_mem(op, 1'b0));
      step({tag, "/mem"}, JUNK, 1'b1, exp_mem(op, 1'b1));
      if (op == OP_LDW) step({tag, "/wb"}, JUNK, 1'b1, exp_wb(op));
    end else if (op != OP_BRZ && op != OP_JAL) begin
      step({tag, "/wb"}, JUNK, 1'b1, exp_wb(op));
    end
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    rst           = 1'b0;
    bus.opcode    = 4'b0000;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    exp_q.push_back(zero_ctl());
    check("reset_low", sample());
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Zero-wait instructions of every class.
    run_instr("alu0000", 4'b0000, 0, 0);
    run_instr("alu0101", 4'b0101, 0, 0);
    run_instr("alu0111", 4'b0111, 0, 0);
    run_instr("adi",     OP_ADI,  0, 0);
    run_instr("swp",     OP_SWP,  0, 0);
    run_instr("brz",     OP_BRZ,  0, 0);
    run_instr("ldw0",    OP_LDW,  0, 0);

    // Load with three memory wait cycles, then store followed by JAL.
    run_instr("ldw3",    OP_LDW,  0, 3);
    run_instr("stw",     OP_STW,  0, 0);
    run_instr("jal",     OP_JAL,  0, 0);

    // Timeout boundary: ready arrives on the last allowed wait cycle.
    run_instr("fetch_edge", 4'b0011, TIMEOUT - 1, 0);
    run_instr("mem_edge",   OP_LDW,  0, TIMEOUT - 1);
    run_instr("stw_wait",   OP_STW,  2, 4);

    // Illegal opcode 1110: sticky trap, stray mem_ready ignored.
    step("ill_e/fetch", JUNK, 1'b1, exp_fetch(1'b1));
    step("ill_e/decode", 4'b1110, 1'b1, base(3'd1));
    fault_exp = 2'b01;
    for (int i = 0; i < 20; i++) step("ill_e/trap", JUNK, i[0], base(3'd7));
    do_reset("ill_e_rst");
    run_instr("after_ill", OP_ADI, 0, 0);

    // Illegal opcode 1111.
    step("ill_f/fetch", JUNK, 1'b1, exp_fetch(1'b1));
    step("ill_f/decode", 4'b1111, 1'b1, base(3'd1));
    fault_exp = 2'b01;
    for (int i = 0; i < 3; i++) step("ill_f/trap", JUNK, 1'b1, base(3'd7));
    do_reset("ill_f_rst");

    // Fetch timeout: mem_ready held low for TIMEOUT cycles.
    for (int i = 0; i < TIMEOUT; i++) step("fto/wait", JUNK, 1'b0, exp_fetch(1'b0));
    fault_exp = 2'b10;
    for (int i = 0; i < 5; i++) step("fto/trap", JUNK, i[0], base(3'd7));
    do_reset("fto_rst");

    // Memory timeout during a store.
    step("mto/fetch", JUNK, 1'b1, exp_fetch(1'b1));
    step("mto/decode", OP_STW, 1'b1, base(3'd1));
    step("mto/exec", JUNK, 1'b1, exp_exec(OP_STW));
    for (int i = 0; i < TIMEOUT; i++) step("mto/wait", JUNK, 1'b0, exp_mem(OP_STW, 1'b0));
    fault_exp = 2'b10;
    for (int i = 0; i < 3; i++) step("mto/trap", JUNK, 1'b1, base(3'd7));
    do_reset("mto_rst");

    // Reset in the middle of a load's memory phase.
    step("rld/fetch", JUNK, 1'b1, exp_fetch(1'b1));
    step("rld/decode", OP_LDW, 1'b1, base(3'd1));
    step("rld/exec", JUNK, 1'b1, exp_exec(OP_LDW));
    step("rld/mem", JUNK, 1'b0, exp_mem(OP_LDW, 1'b0));
    step("rld/mem", JUNK, 1'b0, exp_mem(OP_LDW, 1'b0));
    bus.mem_ready = 1'b1;
    do_reset("rld_rst");
    run_instr("after_rld", 4'b0010, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
